mont_final_sub: RTL

MONT_FINAL_SUB -- requirements
Module: mont_final_sub

---
 rtl/mont_pkg.sv | 22 ++
 rtl/limb_sub.sv | 21 ++
 rtl/mont_final_sub.sv | 116 +++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery final-subtraction block.
// Configuration macro: FINAL_SUB_WIDE_LIMB_EN selects 128-bit limbs (default 64-bit).
package mont_pkg;

`ifdef FINAL_SUB_WIDE_LIMB_EN
  localparam int unsigned LIMB_W = 128;
`else
  localparam int unsigned LIMB_W = 64;
`endif

  // Limbs needed to cover a WIDTH+4 bit sum.
  function automatic int unsigned n_limbs(input int unsigned width);
    return (width + 4 + LIMB_W - 1) / LIMB_W;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StSub,
    StSel
  } state_e;

endpackage

// File: rtl/limb_sub.sv
// One-limb subtract with borrow-in/borrow-out; purely combinational.
module limb_sub #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] diff;

  // Extra top bit becomes the borrow when a - b - bin goes negative.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d    = diff[W-1:0];
    bout = diff[W];
  end

endmodule

// File: rtl/mont_final_sub.sv
// Final conditional subtraction of a Montgomery product: result = (T >= M) ? T - M : T,
// done one limb per cycle with a fixed latency of N_LIMBS+1 cycles.
// Configuration macro: FINAL_SUB_WIDE_LIMB_EN (see mont_pkg) selects the limb width.
module mont_final_sub
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH+3:0] in_t,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             reduced,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NLimbs = n_limbs(WIDTH);
  localparam int unsigned TotW   = NLimbs * LIMB_W;
  localparam int unsigned CntW   = (NLimbs > 1) ? $clog2(NLimbs) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NLimbs - 1);

  state_e state_q, state_d;

  logic [TotW-1:0]   t_sh_q, m_sh_q, diff_q;
  logic [WIDTH-1:0]  t_low_q;
  logic [CntW-1:0]   cnt_q;
  logic              borrow_q;
  logic [WIDTH-1:0]  result_q;
  logic              reduced_q, done_q;

  logic [LIMB_W-1:0] d_limb;
  logic              b_out;

  // Operands shift right so the current limb is always at the bottom.
  limb_sub #(
    .W (LIMB_W)
  ) u_limb_sub (
    .a    (t_sh_q[LIMB_W-1:0]),
    .b    (m_sh_q[LIMB_W-1:0]),
    .bin  (borrow_q),
    .d    (d_limb),
    .bout (b_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != StIdle);
    case (state_q)
      StIdle:  if (start) state_d = StSub;
      StSub:   if (cnt_q == CntLast) state_d = StSel;
      StSel:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: capture, limb-serial subtract, final select.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_sh_q    <= '0;
      m_sh_q    <= '0;
      diff_q    <= '0;
      t_low_q   <= '0;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      result_q  <= '0;
      reduced_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            t_sh_q   <= TotW'(in_t);
            m_sh_q   <= TotW'(in_m);
            t_low_q  <= in_t[WIDTH-1:0];
            cnt_q    <= '0;
            borrow_q <= 1'b0;
          end
        end
        StSub: begin
          t_sh_q   <= t_sh_q >> LIMB_W;
          m_sh_q   <= m_sh_q >> LIMB_W;
          // New limb enters at the top; after NLimbs shifts limb 0 sits at the bottom.
          diff_q   <= TotW'({d_limb, diff_q} >> LIMB_W);
          borrow_q <= b_out;
          cnt_q    <= (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end
        StSel: begin
          // No final borrow means T >= M.
          result_q  <= borrow_q ? t_low_q : diff_q[WIDTH-1:0];
          reduced_q <= ~borrow_q;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result  = result_q;
  assign reduced = reduced_q;
  assign done    = done_q;

endmodule
